// File: rtl/qrs_pkg.sv
// qrs_pkg: shared state encoding, averaging depth and arithmetic helpers for the QRS controller
package qrs_pkg;
   typedef enum logic [2:0] {IDLE, LEARN, TH_INIT, RUN, UPDATE, REFRACT} state_t;
   localparam int RR_AVG_LOG2_DEF = 3;
   localparam int RR_DEPTH = 1 << RR_AVG_LOG2_DEF;
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
      logic [31:0] s, lim;
      s = a + b;
      lim = (32'd1 << w) - 32'd1;
      return s > lim ? lim : s;
   endfunction
   function automatic logic [31:0] mod_diff(input logic [31:0] a, input logic [31:0] b, input int w);
      return (a - b) & ((32'd1 << w) - 32'd1);
   endfunction
endpackage

// File: rtl/rr_avg_buffer.sv
// rr_avg_buffer: RR ring buffer with running sum; fill preloads every entry, push replaces the oldest
module rr_avg_buffer
   import qrs_pkg::*;
#(
   parameter int DATA_WIDTH  = 11,
   parameter int RR_AVG_LOG2 = RR_AVG_LOG2_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_fill,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_rr,
   output logic [DATA_WIDTH-1:0] o_avg
);
   localparam int DEPTH = 1 << RR_AVG_LOG2;
   localparam int SW = DATA_WIDTH + RR_AVG_LOG2;
   logic [DATA_WIDTH-1:0]  ring [DEPTH];
   logic [RR_AVG_LOG2-1:0] wp;
   logic [SW-1:0]          sum;
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
         wp <= '0;
         sum <= '0;
      end else if (i_fill) begin
         for (int i = 0; i < DEPTH; i++) ring[i] <= i_rr;
         wp <= '0;
         sum <= SW'(i_rr) << RR_AVG_LOG2;
      end else if (i_push) begin
         ring[wp] <= i_rr;
         wp <= wp + RR_AVG_LOG2'(1);
         sum <= sum - SW'(ring[wp]) + SW'(i_rr);
      end
   assign o_avg = DATA_WIDTH'(sum >> RR_AVG_LOG2);
endmodule

// File: rtl/qrs_adaptive_fsm.sv
// qrs_adaptive_fsm: learns a QRS threshold, then tracks beats, RR average, refractory window and missed beats
module qrs_adaptive_fsm
   import qrs_pkg::*;
#(
   parameter int DATA_WIDTH     = 11,
   parameter int CTR_WIDTH      = 24,
   parameter int INIT_LEN       = 1080,
   parameter int REFRACT_LEN    = 72,
   parameter int TH_DECAY_SHIFT = 5,
   parameter int TH_GAIN_SHIFT  = 6,
   parameter int RR_AVG_LOG2    = RR_AVG_LOG2_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_ce,
   input  logic [CTR_WIDTH-1:0]  i_ctr,
   input  logic [DATA_WIDTH-1:0] i_amp,
   input  logic                  i_amp_valid,
   input  logic                  i_extremum_found,
   output logic                  o_qrs_search_en,
   output logic [DATA_WIDTH-1:0] o_qrs_threshold,
   output logic [CTR_WIDTH-1:0]  o_r_peak_sample_num,
   output logic                  o_r_peak_valid,
   output logic [DATA_WIDTH-1:0] o_rr_period,
   output logic [DATA_WIDTH-1:0] o_rr_avg,
   output logic                  o_rr_updated,
   output logic                  o_beat_missed,
   output logic                  o_learning
);
   state_t                state, state_nxt;
   logic [CTR_WIDTH-1:0]  cnt, elapsed;
   logic [DATA_WIDTH-1:0] max_acc, rr, th_upd;
   logic [1:0]            beat_cnt;
   logic                  miss_armed, miss, fill, push;
   assign elapsed = CTR_WIDTH'(mod_diff(32'(i_ctr), 32'(o_r_peak_sample_num), CTR_WIDTH));
   assign rr = DATA_WIDTH'(sat_add(32'(elapsed), 32'd0, DATA_WIDTH));
   assign th_upd = DATA_WIDTH'(sat_add(32'(o_qrs_threshold - (o_qrs_threshold >> TH_DECAY_SHIFT)),
                                       32'(i_amp >> TH_GAIN_SHIFT), DATA_WIDTH));
   // timeout at 150% of the running average, armed once per accepted beat
   assign miss = beat_cnt >= 2'd2 && miss_armed &&
                 32'(elapsed) > 32'(o_rr_avg) + 32'(o_rr_avg >> 1);
   assign fill = state == UPDATE && beat_cnt == 2'd1;
   assign push = state == UPDATE && beat_cnt >= 2'd2;
   assign o_learning = state == LEARN;
   rr_avg_buffer #(.DATA_WIDTH(DATA_WIDTH), .RR_AVG_LOG2(RR_AVG_LOG2)) u_rr (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_fill (fill),
      .i_push (push),
      .i_rr   (rr),
      .o_avg  (o_rr_avg)
   );
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = i_ce && i_amp_valid ? LEARN : IDLE;
         LEARN:   state_nxt = i_ce && cnt == '0 ? TH_INIT : LEARN;
         TH_INIT: state_nxt = RUN;
         RUN:     state_nxt = i_ce && i_extremum_found ? UPDATE : RUN;
         UPDATE:  state_nxt = REFRACT;
         REFRACT: state_nxt = i_ce && cnt == '0 ? RUN : REFRACT;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         state <= IDLE;
         cnt <= '0;
         max_acc <= '0;
         beat_cnt <= '0;
         miss_armed <= 1'b0;
         o_qrs_search_en <= 1'b0;
         o_qrs_threshold <= '0;
         o_r_peak_sample_num <= '0;
         o_r_peak_valid <= 1'b0;
         o_rr_period <= '0;
         o_rr_updated <= 1'b0;
         o_beat_missed <= 1'b0;
      end else begin
         state <= state_nxt;
         o_qrs_search_en <= state_nxt == RUN;
         o_r_peak_valid <= state == UPDATE;
         o_rr_updated <= fill | push;
         o_beat_missed <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= CTR_WIDTH'(INIT_LEN - 1);
               max_acc <= '0;
            end
            LEARN: if (i_ce) begin
               if (i_amp_valid && i_amp > max_acc) max_acc <= i_amp;
               cnt <= cnt - CTR_WIDTH'(1);
            end
            TH_INIT: begin
               o_qrs_threshold <= max_acc >> 1;
               beat_cnt <= '0;
               miss_armed <= 1'b0;
            end
            RUN: if (i_ce && !i_extremum_found && miss) begin
               o_beat_missed <= 1'b1;
               o_qrs_threshold <= o_qrs_threshold >> 1;
               miss_armed <= 1'b0;
            end
            UPDATE: begin
               o_r_peak_sample_num <= i_ctr;
               o_qrs_threshold <= th_upd;
               if (beat_cnt != 2'd0) o_rr_period <= rr;
               if (beat_cnt != 2'd3) beat_cnt <= beat_cnt + 2'd1;
               miss_armed <= 1'b1;
               cnt <= CTR_WIDTH'(REFRACT_LEN - 1);
            end
            REFRACT: if (i_ce) cnt <= cnt - CTR_WIDTH'(1);
            default: ;
         endcase
      end
endmodule
